cbd_stream_sampler: RTL
=======================

# cbd_stream_sampler

Parametrised streaming centered-binomial-distribution sampler for the Kyber secret/noise path. It consumes a PRF byte stream over a valid/ready handshake and emits one polynomial of N_COEFF signed coefficients in CBD_ETA form, with backpressure on both sides. It replaces the fixed-η, whole-array CBD with a block that supports η = 2 or 3 and sits between the PRF/XOF output buffer and the NTT input FIFO.

## Interface
- ETA, default 2: CBD parameter. Only 2 and 3 are legal; any other value is an elaboration `$error`.
- N_COEFF, default 256: coefficients per polynomial.
- COEFF_W, default 4: signed coefficient width. Must be ≥ 3.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a polynomial. Honoured only in IDLE.
- in_data  in  8  PRF byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- coeff  out  COEFF_W  signed coefficient in [-ETA, ETA].
- coeff_idx  out  $clog2(N_COEFF)  index of the coefficient currently presented.
- coeff_last  out  1  high with coeff_idx = N_COEFF-1.
- coeff_valid  out  1  output valid.
- coeff_ready  in  1  coefficient consumed when coeff_valid & coeff_ready.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last coefficient is consumed.

## Operation
- Bit order follows FIPS 203. Bit i of the stream is `(B[i/8] >> (i%8)) & 1`.
- Coefficient j:
  - a = sum of bits 2jη … 2jη+η-1.
  - b = sum of bits 2jη+η … 2jη+2η-1.
  - f = a − b, sign-extended to COEFF_W.
- Internal bit buffer: 16 bits plus a 5-bit fill count. New bytes are appended at bit position `count`. Consumed bits are shifted out from the LSB.
- Byte budget is 64·ETA bytes per polynomial. The block never accepts more.
- in_ready = (state==RUN) & (count ≤ 8) & (bytes_taken < 64·ETA).
- Output register:
  - Loads a new coefficient when count ≥ 2η and (coeff_valid is low or the current coefficient is being consumed).
  - coeff, coeff_idx and coeff_last are held stable while coeff_valid & !coeff_ready.
- FSM:
  - IDLE → RUN on start. Clears the buffer, count, byte and coefficient counters.
  - RUN → DONE on the handshake of the coefficient with coeff_idx = N_COEFF-1.
  - DONE → IDLE after one cycle. done is high during DONE.
  - start while in RUN or DONE is ignored.
- Simultaneous byte accept and coefficient generation in the same cycle is required. The new count is count + 8 − 2η.
- η=3: leftover bits straddle byte boundaries. After 3 bytes exactly 4 coefficients are produced and count returns to 0.
- Any bits left at polynomial end are discarded on the next start. With a legal ETA none remain.

## Timing
- Reset values: in_ready=0, coeff=0, coeff_idx=0, coeff_last=0, coeff_valid=0, busy=0, done=0. State=IDLE, count=0.
- in_ready rises the cycle after the start pulse.
- Latency: a byte accepted at edge E that completes ≥ 2η buffered bits makes coeff_valid high after edge E+1.
- Throughput: one coefficient per cycle whenever the buffer holds ≥ 2η bits and coeff_ready=1.
  - η=2: the input is never the bottleneck. Sustained rate is 2 coefficients per byte.
  - η=3: sustained rate is 4 coefficients per 3 bytes.
- done is asserted exactly 1 cycle after the final handshake. busy drops in the same cycle.
- rst_n asserted mid-polynomial clears everything immediately (asynchronous). There is no partial output afterwards.

## Configuration
- CBD_MODQ_OUT_EN:
  - Defined: adds output port `coeff_modq` (12 bits), registered alongside coeff, equal to f mod 3329 in [0, 3328] (e.g. −1 → 3328). It is held under backpressure like coeff and resets to 0.
  - Undefined: the port and its logic are absent.

## Test plan
- ETA=2, start, stream 0xEF, 0x03, 0x0C, then 125 × 0x00 with coeff_ready=1 → coefficients 0, −1, 2, 0, −2, 0, then all 0. coeff_last at idx 255. done pulses once. The 129th byte is not accepted (in_ready=0).
- ETA=3, bytes 0x07, 0x00, 0x00, 0x38, 0x00, 0x00, … (192 total) → idx0=+3, idx1–3=0, idx4=−3. Exactly 256 coefficients are produced.
- Backpressure: coeff_ready toggled pseudo-randomly, in_valid gapped → coeff and idx stable while stalled. No coefficient is lost or duplicated; the sequence matches the golden model.
- rst_n pulsed low at idx 100 → all outputs 0 immediately. A new start yields idx 0 from fresh bytes.
- start pulsed during RUN → ignored; the counters continue uninterrupted.
- With CBD_MODQ_OUT_EN, ETA=3 vector above → coeff_modq = 3 then 3326 for idx0 and idx4.

Source files
------------

// File: rtl/cbd_stream_sampler.sv
// Streaming centered-binomial-distribution sampler (eta = 2 or 3).
// Consumes a PRF byte stream into a 16-bit bit buffer and emits N_COEFF signed
// coefficients over a valid/ready handshake, with backpressure on both sides.
// Optional feature macro: CBD_MODQ_OUT_EN adds the coeff_modq output (f mod 3329).
module cbd_stream_sampler #(
    parameter int ETA     = 2,
    parameter int N_COEFF = 256,
    parameter int COEFF_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [COEFF_W-1:0]  coeff,
    output logic [$clog2(N_COEFF)-1:0] coeff_idx,
    output logic                       coeff_last,
    output logic                       coeff_valid,
    input  logic                       coeff_ready,
    output logic                       busy,
    output logic                       done
`ifdef CBD_MODQ_OUT_EN
    ,
    output logic [11:0]                coeff_modq
`endif
);

    localparam int IDXW   = $clog2(N_COEFF);
    localparam int SH     = 2 * ETA;
    localparam int BUDGET = 64 * ETA;
    localparam int BW     = $clog2(BUDGET + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (ETA != 2 && ETA != 3) begin : g_eta_chk
        $error("cbd_stream_sampler: ETA must be 2 or 3");
    end
    if (COEFF_W < 3) begin : g_w_chk
        $error("cbd_stream_sampler: COEFF_W must be >= 3");
    end

    logic [1:0]                state_q, state_d;
    logic [15:0]               buf_q, buf_d;
    logic [4:0]                cnt_q, cnt_d;
    logic [BW-1:0]             bytes_q, bytes_d;
    logic [IDXW:0]             gen_q, gen_d;
    logic signed [COEFF_W-1:0] coeff_q, coeff_d;
    logic [IDXW-1:0]           idx_q, idx_d;
    logic                      last_q, last_d;
    logic                      valid_q, valid_d;
    logic [11:0]               modq_q, modq_d;

    logic                      accept, fire, load;
    logic [1:0]                a_sum, b_sum;
    logic signed [COEFF_W-1:0] f;
    logic [15:0]               base_buf;
    logic [4:0]                base_cnt;

    assign in_ready = (state_q == S_RUN) && (cnt_q <= 5'd8) && (bytes_q < BW'(BUDGET));
    assign accept   = in_valid && in_ready;
    assign fire     = valid_q && coeff_ready;
    assign load     = (state_q == S_RUN) && (cnt_q >= 5'(SH)) &&
                      (gen_q < (IDXW+1)'(N_COEFF)) && (!valid_q || coeff_ready);

    assign coeff       = coeff_q;
    assign coeff_idx   = idx_q;
    assign coeff_last  = last_q;
    assign coeff_valid = valid_q;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
`ifdef CBD_MODQ_OUT_EN
    assign coeff_modq  = modq_q;
`endif

    // Popcounts of the two eta-bit halves at the bottom of the buffer.
    always_comb begin
        a_sum = '0;
        b_sum = '0;
        for (int unsigned k = 0; k < ETA; k++) begin
            a_sum = a_sum + 2'(buf_q[k]);
            b_sum = b_sum + 2'(buf_q[ETA+k]);
        end
    end

    assign f = $signed(COEFF_W'(a_sum)) - $signed(COEFF_W'(b_sum));

    // Next-state: bit buffer, counters, output register and FSM.
    always_comb begin
        state_d = state_q;
        gen_d   = gen_q;
        coeff_d = coeff_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        modq_d  = modq_q;
        bytes_d = bytes_q;

        // Consume first, then append at the post-consume fill level so that a
        // byte accept and a coefficient load can share one cycle.
        base_buf = load ? (buf_q >> SH) : buf_q;
        base_cnt = load ? (cnt_q - 5'(SH)) : cnt_q;
        buf_d    = base_buf;
        cnt_d    = base_cnt;
        if (accept) begin
            buf_d   = base_buf | (16'(in_data) << base_cnt);
            cnt_d   = base_cnt + 5'd8;
            bytes_d = bytes_q + BW'(1);
        end

        if (load) begin
            coeff_d = f;
            idx_d   = gen_q[IDXW-1:0];
            last_d  = (gen_q == (IDXW+1)'(N_COEFF - 1));
            valid_d = 1'b1;
            gen_d   = gen_q + (IDXW+1)'(1);
            modq_d  = (a_sum >= b_sum) ? 12'(a_sum - b_sum)
                                       : 12'd3329 - 12'(b_sum - a_sum);
        end else if (fire) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    buf_d   = '0;
                    cnt_d   = '0;
                    bytes_d = '0;
                    gen_d   = '0;
                    coeff_d = '0;
                    idx_d   = '0;
                    last_d  = 1'b0;
                    valid_d = 1'b0;
                    modq_d  = '0;
                end
            end
            S_RUN: begin
                if (fire && last_q) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            bytes_q <= '0;
            gen_q   <= '0;
            coeff_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            modq_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            bytes_q <= bytes_d;
            gen_q   <= gen_d;
            coeff_q <= coeff_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            modq_q  <= modq_d;
        end
    end

endmodule
